// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: single-port memory exerciser.
// Writes an incrementing pattern (seed + i) to a window of N = cfg_len + 1
// words starting at cfg_base (address wraps at the top of memory), reads the
// window back and compares it against the expected pattern.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle run request, honoured only in IDLE
//   cfg_base/len/seed   run configuration, captured on accept
//   mem_ce/we/addr/din  registered memory request
//   mem_dout            memory read data, valid RD_LAT cycles after a read
//   busy, done          run in progress / one-cycle completion pulse
//   err_cnt             saturating mismatch count of the last run
//   err_first_addr      address of the first mismatch of the last run
//   err_seen            at least one mismatch in the last run
//
// Optional build macro MEM_TRAFFIC_THROTTLE_EN: a free-running modulo
// THR_PERIOD counter forces a bubble (no issue) on every WRITE/READ cycle
// where it reads zero.
module mem_traffic_gen #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 10,
  parameter int RD_LAT     = 1,
  parameter int THR_PERIOD = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic [AWIDTH-1:0] cfg_len,
  input  logic [DWIDTH-1:0] cfg_seed,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [AWIDTH-1:0] err_first_addr,
  output logic              err_seen
);

  localparam int unsigned LAT = RD_LAT;

  if (DWIDTH < 1 || DWIDTH > 128 || AWIDTH < 1 || AWIDTH > 20 ||
      RD_LAT < 1 || RD_LAT > 8 || THR_PERIOD < 2 || THR_PERIOD > 255) begin : g_bad_param
    $error("mem_traffic_gen: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN} state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_base, r_len, r_idx, r_addr_nx;
  logic [DWIDTH-1:0] r_seed, r_data_nx, r_exp;
  logic              r_mem_ce, r_mem_we;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_din;
  logic              r_busy, r_done, r_err_seen;
  logic [15:0]       r_err_cnt;
  logic [AWIDTH-1:0] r_err_first;

  // Read-compare pipeline; stage 0 is loaded from the registered read request.
  logic [LAT-1:0]    r_pv;
  logic [AWIDTH-1:0] r_pa [LAT];
  logic [DWIDTH-1:0] r_pd [LAT];

  logic w_bubble, w_drained, w_mis;

`ifdef MEM_TRAFFIC_THROTTLE_EN
  localparam logic [7:0] THR_LAST = 8'(THR_PERIOD - 1);
  logic [7:0] r_thr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_thr <= '0;
    else     r_thr <= (r_thr == THR_LAST) ? '0 : r_thr + 8'd1;
  end

  assign w_bubble = (r_thr == '0);
`else
  assign w_bubble = 1'b0;
`endif

  // Empty once the entry leaving the last stage this edge is the only one:
  // no read request still on the bus and no entry in earlier stages.
  always_comb begin
    w_drained = !(r_mem_ce && !r_mem_we);
    for (int unsigned k = 0; k + 1 < LAT; k++) begin
      if (r_pv[k]) w_drained = 1'b0;
    end
  end

  assign w_mis = r_pv[LAT-1] && (mem_dout != r_pd[LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        r_pa[k] <= '0;
        r_pd[k] <= '0;
      end
    end else begin
      r_pv[0] <= r_mem_ce & ~r_mem_we;
      r_pa[0] <= r_mem_addr;
      r_pd[0] <= r_exp;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pa[k] <= r_pa[k-1];
        r_pd[k] <= r_pd[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_addr_nx   <= '0;
      r_data_nx   <= '0;
      r_exp       <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_err_first <= '0;
      r_err_seen  <= 1'b0;
    end else begin
      r_mem_ce <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;

      if (w_mis) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_err_seen)     r_err_first <= r_pa[LAT-1];
        r_err_seen <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base      <= cfg_base;
            r_len       <= cfg_len;
            r_seed      <= cfg_seed;
            r_idx       <= '0;
            r_addr_nx   <= cfg_base;
            r_data_nx   <= cfg_seed;
            r_err_cnt   <= '0;
            r_err_first <= '0;
            r_err_seen  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!w_bubble) begin
            r_mem_ce   <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr_nx;
            r_mem_din  <= r_data_nx;
            r_addr_nx  <= r_addr_nx + 1'b1;
            r_data_nx  <= r_data_nx + 1'b1;
            r_idx      <= r_idx + 1'b1;
            if (r_idx == r_len) r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_idx     <= '0;
          r_addr_nx <= r_base;
          r_data_nx <= r_seed;
          r_state   <= S_READ;
        end
        S_READ: begin
          if (!w_bubble) begin
            r_mem_ce   <= 1'b1;
            r_mem_addr <= r_addr_nx;
            r_exp      <= r_data_nx;
            r_addr_nx  <= r_addr_nx + 1'b1;
            r_data_nx  <= r_data_nx + 1'b1;
            r_idx      <= r_idx + 1'b1;
            if (r_idx == r_len) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // done is shown during the final DRAIN cycle, so a start in that
          // cycle still meets a non-IDLE state.
          if (r_done) begin
            r_state <= S_IDLE;
          end else if (w_drained) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ce         = r_mem_ce;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_din        = r_mem_din;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign err_first_addr = r_err_first;
  assign err_seen       = r_err_seen;

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Testbench for mem_traffic_gen: ideal memory with optional bit-0 fault on
// addresses 0x005/0x006, a transaction-queue model of the expected bus
// traffic and run results, and directed runs with literal expectations.
module tb_mem_traffic_gen;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int RDL = 1;
  localparam int THR = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len = '0;
  logic [DW-1:0] cfg_seed = '0;
  logic          mem_ce, mem_we, busy, done, err_seen;
  logic [AW-1:0] mem_addr, err_first_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [15:0]   err_cnt;

  mem_traffic_gen #(.DWIDTH(DW), .AWIDTH(AW), .RD_LAT(RDL), .THR_PERIOD(THR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .done(done), .err_cnt(err_cnt),
    .err_first_addr(err_first_addr), .err_seen(err_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory under test
  logic          fault_en = 1'b0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rp  [RDL];

  function automatic logic is_fault(input logic [AW-1:0] a);
    return fault_en && (a == 10'h005 || a == 10'h006);
  endfunction

  always @(posedge clk) begin
    if (mem_ce && mem_we) mem[mem_addr] <= mem_din;
    rp[0] <= (mem_ce && !mem_we) ? (mem[mem_addr] ^ {{(DW-1){1'b0}}, is_fault(mem_addr)}) : '0;
    for (int k = 1; k < RDL; k++) rp[k] <= rp[k-1];
  end
  assign mem_dout = rp[RDL-1];

  // Model
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  txn_t          exp_q[$];
  int            checks = 0, errors = 0;
  int            acc_cyc = 0, exp_done = 0, last_done = 0;
  bit            run_live = 1'b0;
  logic [15:0]   m_cnt = '0;
  logic [AW-1:0] m_first = '0;
  logic          m_seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic model_accept(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s);
    int n;
    txn_t t;
    n = int'(l) + 1;
    m_cnt = '0; m_first = '0; m_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      t.we = 1'b1; t.a = b + AW'(i); t.d = s + DW'(i);
      exp_q.push_back(t);
    end
    for (int i = 0; i < n; i++) begin
      t.we = 1'b0; t.a = b + AW'(i); t.d = s + DW'(i);
      exp_q.push_back(t);
      if (is_fault(t.a)) begin
        if (!m_seen) m_first = t.a;
        m_seen = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end
    acc_cyc  = cyc;
    exp_done = cyc + 2 * n + RDL + 2;
    run_live = 1'b1;
  endtask

`ifdef MEM_TRAFFIC_THROTTLE_EN
  int thr = 0, thr_edge = 1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      thr <= 0; thr_edge <= 1;
    end else begin
      thr_edge <= thr;
      thr <= (thr == THR - 1) ? 0 : thr + 1;
    end
  end
`endif

  // Per-cycle compare
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ce) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_access got ce=1 addr=%0h want no access (cycle %0d)", mem_addr, cyc);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          check("bus_we", mem_we, t.we);
          check("bus_addr", mem_addr, t.a);
          if (t.we) check("bus_din", mem_din, t.d);
        end
      end else begin
        check("we_without_ce", mem_we, 1'b0);
      end
`ifdef MEM_TRAFFIC_THROTTLE_EN
      if (thr_edge == 0) check("bubble_ce", mem_ce, 1'b0);
`endif
      if (run_live) begin
        if (cyc == acc_cyc) begin
          check("clr_cnt", err_cnt, 16'h0);
          check("clr_first", err_first_addr, '0);
          check("clr_seen", err_seen, 1'b0);
        end
`ifndef MEM_TRAFFIC_THROTTLE_EN
        check("busy", busy, cyc < exp_done);
        check("done", done, cyc == exp_done);
`else
        check("busy", busy, !done);
`endif
        if (done) begin
          check("res_cnt", err_cnt, m_cnt);
          check("res_first", err_first_addr, m_first);
          check("res_seen", err_seen, m_seen);
          check("all_issued", exp_q.size(), 0);
          last_done = cyc;
          run_live  = 1'b0;
        end
      end else begin
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("hold_cnt", err_cnt, m_cnt);
        check("hold_first", err_first_addr, m_first);
        check("hold_seen", err_seen, m_seen);
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s);
    @(negedge clk);
    start = 1'b1; cfg_base = b; cfg_len = l; cfg_seed = s;
    @(posedge clk); #1;
    start = 1'b0;
    model_accept(b, l, s);
  endtask

  task automatic pulse_ignored_start();
    start = 1'b1; cfg_base = 10'h2AA; cfg_len = 10'h001; cfg_seed = 32'hBAD0_0000;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (!run_live) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout got no done want done within 3000 cycles");
    run_live = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1;
    check("rst_ce", mem_ce, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, '0);
    check("rst_din", mem_din, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnt", err_cnt, 16'h0);
    check("rst_first", err_first_addr, '0);
    check("rst_seen", err_seen, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic run, 8 words
    start_run(10'h000, 10'd7, 32'h1000_0000);
`ifndef MEM_TRAFFIC_THROTTLE_EN
    repeat (2) @(negedge clk);
    check("t1_addr0", mem_addr, 10'h000);
    check("t1_din0", mem_din, 32'h1000_0000);
    check("t1_we0", mem_we, 1'b1);
    repeat (7) @(negedge clk);
    check("t1_addr7", mem_addr, 10'h007);
    check("t1_din7", mem_din, 32'h1000_0007);
`endif
    wait_done();
`ifndef MEM_TRAFFIC_THROTTLE_EN
    check("t1_latency", last_done - acc_cyc, 19);
`endif
    check("t1_err_cnt", err_cnt, 16'h0);
    check("t1_err_seen", err_seen, 1'b0);

    // Address wrap at the top of memory
    start_run(10'h3FE, 10'd3, 32'hA5A5_0000);
`ifndef MEM_TRAFFIC_THROTTLE_EN
    repeat (4) @(negedge clk);
    check("t2_wrap_addr", mem_addr, 10'h000);
    check("t2_wrap_din", mem_din, 32'hA5A5_0002);
`endif
    wait_done();
    check("t2_err_cnt", err_cnt, 16'h0);

    // Fault injection with starts mid-run and on the done cycle
    fault_en = 1'b1;
    start_run(10'h000, 10'd7, 32'hDEAD_0000);
    repeat (5) @(negedge clk);
    pulse_ignored_start();
    wait_done();
    start = 1'b1;
    check("t3_err_cnt", err_cnt, 16'd2);
    check("t3_err_first", err_first_addr, 10'h005);
    check("t3_err_seen", err_seen, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    fault_en = 1'b0;
    start_run(10'h100, 10'd3, 32'h0000_0005);
    wait_done();
    check("t4_err_cleared", err_cnt, 16'h0);

    // Reset during READ
    start_run(10'h000, 10'd7, 32'h7777_0000);
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ce", mem_ce, 1'b0);
    check("t5_rst_addr", mem_addr, '0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_cnt", err_cnt, 16'h0);
    run_live = 1'b0;
    exp_q.delete();
    m_cnt = '0; m_first = '0; m_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(10'h020, 10'd5, 32'h0123_4567);
    wait_done();
    check("t5_err_cnt", err_cnt, 16'h0);

    // Single word
    start_run(10'h3FF, 10'd0, 32'h0000_0001);
    wait_done();
`ifndef MEM_TRAFFIC_THROTTLE_EN
    check("t6_latency", last_done - acc_cyc, 5);
`endif

    // 32 words with data wrapping past all-ones
    start_run(10'h040, 10'd31, 32'hFFFF_FFF0);
    wait_done();
    check("t7_err_cnt", err_cnt, 16'h0);
`ifdef MEM_TRAFFIC_THROTTLE_EN
    check("t7_len_grew", (last_done - acc_cyc) > 67, 1'b1);
`else
    check("t7_latency", last_done - acc_cyc, 67);
`endif

    // Full memory window
    start_run(10'h200, 10'h3FF, 32'h0000_0000);
    wait_done();
    check("t8_err_cnt", err_cnt, 16'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_traffic_gen.md
Name: mem_traffic_gen

Overview:
- Parametrised single-port memory exerciser, one instance per memory under test.
- Generalises the hard-wired counter/modulo write-enable stimulus into a configurable engine: base/length/seed, pattern write, read-back, compare.
- Sits between a sequencing controller (start/done) and one memory instance (ce/we/addr/din/dout).
- Reports mismatch count and the first failing address.

Parameters:
- DWIDTH, 32, memory data width in bits (1..128).
- AWIDTH, 10, memory address width in bits (1..20).
- RD_LAT, 1, cycles from a read request (mem_ce=1, mem_we=0) to valid mem_dout (1..8).
- THR_PERIOD, 17, throttle modulo; used only when the optional feature is compiled in (2..255).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cfg_base  in  AWIDTH  first word address; sampled when start is accepted.
- cfg_len  in  AWIDTH  word count minus one; sampled when start is accepted.
- cfg_seed  in  DWIDTH  pattern seed; sampled when start is accepted.
- mem_ce  out  1  memory chip enable.
- mem_we  out  1  memory write enable; 1 = write, 0 = read.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_dout  in  DWIDTH  memory read data.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at completion.
- err_cnt  out  16  mismatch count for the last run; saturates at 16'hFFFF.
- err_first_addr  out  AWIDTH  address of the first mismatch of the last run.
- err_seen  out  1  sticky flag: at least one mismatch this run.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; the read pipeline is cleared.
  - mem_ce, mem_we, busy, done, err_seen = 0; mem_addr, mem_din, err_cnt, err_first_addr = 0.
- Word count: N = cfg_len + 1, range 1..2^AWIDTH.
- Word index i runs 0..N-1.
  - Address: (cfg_base + i) mod 2^AWIDTH; wraps silently past the top address.
  - Data: (cfg_seed + i) mod 2^DWIDTH.
- IDLE:
  - start=1 latches the config, clears err_cnt, err_first_addr and err_seen, then moves to WRITE.
  - busy rises on the next cycle.
- WRITE:
  - Each issuing cycle drives mem_ce=1, mem_we=1, address(i), data(i), then increments i.
  - After word N-1, move to GAP.
- GAP: one cycle with mem_ce=0; i resets to 0; then move to READ.
- READ:
  - Each issuing cycle drives mem_ce=1, mem_we=0, address(i).
  - Each read pushes {valid, expected data(i), address(i)} into an RD_LAT-deep shift pipeline.
  - After word N-1, move to DRAIN.
- DRAIN: wait until the pipeline is empty, then move to IDLE. done pulses in that same cycle and busy falls.
- Compare:
  - When a pipeline entry emerges valid, it is compared against mem_dout.
  - On mismatch: err_cnt increments unless already at 16'hFFFF; err_first_addr loads only if err_seen=0; err_seen is set.
- Outputs:
  - mem_ce, mem_we, mem_addr and mem_din are registered.
  - mem_din is don't-care but holds its last value during reads.
  - Outside WRITE/READ issuing cycles, mem_ce=0 and mem_we=0.
- start while busy is ignored; no queueing.
- A new start in the same cycle as done is ignored, because the state is not yet IDLE.
- Nominal run length with N words: 2N + RD_LAT + 2 cycles from accept to done (unthrottled).
- Error results hold until the next accepted start.

Optional Feature:
- Macro: MEM_TRAFFIC_THROTTLE_EN.
- Defined:
  - A free-running 8-bit counter runs from reset; it wraps modulo THR_PERIOD.
  - In WRITE/READ, any cycle where the counter equals 0 is a bubble: mem_ce=0, i holds, no pipeline push.
  - Run length grows by the number of bubbles.
- Undefined: no counter; every WRITE/READ cycle issues; THR_PERIOD is unused.

Test Plan:
- Ideal memory, RD_LAT=1, base=0x000, len=7, seed=0x1000_0000 -> 8 writes at addresses 0..7 with data 0x1000_0000..0x1000_0007, then 8 reads; done at cycle 19 after accept; err_cnt=0, err_seen=0.
- Wrap: base=0x3FE, len=3 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; no errors.
- Fault injection: the model flips bit 0 on reads of address 0x005 and 0x006 -> err_cnt=2, err_first_addr=0x005, err_seen=1.
- start pulsed mid-run and again on the done cycle -> both ignored; a start one cycle after done -> accepted, err counters cleared.
- rst asserted during READ, then released, then a fresh start -> outputs at reset values immediately, no done pulse for the aborted run, new run completes cleanly.
- MEM_TRAFFIC_THROTTLE_EN defined, THR_PERIOD=17, len=31 -> mem_ce low on every counter==0 cycle inside WRITE/READ; all 32 writes and 32 reads still issued; err_cnt=0.
